// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: byte type, forward/inverse S-box tables
// and lane-slicing constants used by the SubBytes datapath.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int BYTE_W    = 8;
    localparam int MAX_LANES = 16;

    // Bit position of the least-significant bit of byte lane `lane` in a packed beat.
    function automatic int lane_lsb(input int lane);
        return lane * BYTE_W;
    endfunction

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_byte.sv
// Combinational single-byte AES S-box lookup. The inverse table is only built
// when SUB_BYTES_INV_SBOX_EN is defined; otherwise `inv` is ignored.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic       inv,
    output logic [7:0] byte_out
);

`ifdef SUB_BYTES_INV_SBOX_EN
    assign byte_out = inv ? SBOX_INV[byte_in] : SBOX_FWD[byte_in];
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign byte_out   = SBOX_FWD[byte_in];
`endif

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage valid/ready AES SubBytes engine, LANES bytes per beat with a pass-through tag.
// SUB_BYTES_INV_SBOX_EN enables the per-beat inverse S-box selected by in_inv.
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*LANES-1:0]     in_data,
    input  logic                   in_inv,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*LANES-1:0]     out_data,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int DATA_W = BYTE_W * LANES;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_inv;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic [TAG_W-1:0]  s2_tag;

    logic [DATA_W-1:0] lut_data;
    logic              s1_load;
    logic              s2_load;

    // S2 refills whenever it is empty or its beat leaves this cycle; S1 refills
    // whenever it is empty or its beat moves into S2.
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LSB = i * BYTE_W;
        aes_sbox_byte u_sbox (
            .byte_in  (s1_data[LSB +: BYTE_W]),
            .inv      (s1_inv),
            .byte_out (lut_data[LSB +: BYTE_W])
        );
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= 1'b1;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // NOTE: only the output-visible data registers are reset; S1 payload is
    // qualified by s1_valid, so it is left unreset and simply holds when not loaded.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_data <= in_data;
            s1_inv  <= in_inv;
            s1_tag  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data <= '0;
            s2_tag  <= '0;
        end else if (s2_load) begin
            s2_data <= lut_data;
            s2_tag  <= s1_tag;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: a GF(2^8) reference model predicts each beat,
// a negedge monitor pops and compares every output transfer.
module tb_sub_bytes_pipe;

    localparam int LANES   = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 8 * LANES;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_inv = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    logic [DATA_W-1:0] last_out_data = '0;

    beat_t exp_q[$];
    int    out_cycs[$];

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    sub_bytes_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: S-box from field inverse + affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] v = 8'h00;
        if (a != 8'h00) begin
            for (int x = 1; x < 256; x++) begin
                if (gmul(a, 8'(x)) == 8'h01) v = 8'(x);
            end
        end
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d, input logic inv);
        logic [DATA_W-1:0] r = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SUB_BYTES_INV_SBOX_EN
            r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
`else
            r[8*i +: 8] = fwd_t[d[8*i +: 8]];
            if (inv) r[8*i +: 8] = fwd_t[d[8*i +: 8]];
`endif
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                last_out_data = out_data;
                out_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h tag %0d with nothing outstanding", out_data, out_tag);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end
    end

    // ---------------- driver (starts and ends just after a rising edge)
    task automatic send(input logic [DATA_W-1:0] d, input logic inv, input logic [TAG_W-1:0] t);
        beat_t e;
        in_data  = d;
        in_inv   = inv;
        in_tag   = t;
        in_valid = 1'b1;
        for (int w = 0; w <= TIMEOUT; w++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = model(d, inv);
                e.tag  = t;
                exp_q.push_back(e);
                acc_cnt++;
                acc_cyc = cyc;
                break;
            end
            if (w == TIMEOUT) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", TIMEOUT);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_outputs(input int n);
        for (int w = 0; w < TIMEOUT && out_cycs.size() < n; w++) tick(1);
        check("output_count", 64'(out_cycs.size()), 64'(n));
    endtask

    initial begin
        int bp_acc;
        logic [DATA_W-1:0] held;
        bit done;

        for (int i = 0; i < 256; i++) fwd_t[i] = sbox_ref(8'(i));
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        // reset state
        tick(3);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // forward directed beat and latency
        out_cycs.delete();
        send(32'hFF530100, 1'b0, 4'd3);
        wait_outputs(1);
        check("latency", 64'(out_cycs[0] - acc_cyc), 64'd2);
        check("fwd_directed", 64'(last_out_data), 64'h16ED7C63);

        // inverse directed beat (forward table only when the feature is off)
        out_cycs.delete();
        send(32'h16ED7C63, 1'b1, 4'd5);
        wait_outputs(1);
`ifdef SUB_BYTES_INV_SBOX_EN
        check("inv_directed", 64'(last_out_data), 64'hFF530100);
`else
        check("inv_ignored", 64'(last_out_data), 64'h475510FB);
`endif

        // mixed mode per beat on all-zero data
        out_cycs.delete();
        for (int k = 0; k < 8; k++) send('0, k[0], 4'(k));
        wait_outputs(8);

        // streaming 256 back-to-back beats
        tick(4);
        out_cycs.delete();
        bp_acc = acc_cnt;
        for (int k = 0; k < 256; k++) send({24'($urandom), 8'(k)}, 1'b0, 4'(k));
        wait_outputs(256);
        check("stream_gapless", 64'(out_cycs[255] - out_cycs[0]), 64'd255);

        // backpressure: 4 beats with out_ready low from the start
        tick(4);
        out_ready = 1'b0;
        bp_acc = acc_cnt;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send(DATA_W'($urandom), 1'($urandom), 4'(k + 8));
                done = 1'b1;
            end
            begin
                tick(6);
                @(negedge clk);
                check("bp_accepted", 64'(acc_cnt - bp_acc), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                held = out_data;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                    check("bp_hold_data", 64'(out_data), 64'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int w = 0; w < TIMEOUT && !done; w++) tick(1);
                check("bp_done", 64'(done), 64'd1);
            end
        join
        tick(4);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // randomized traffic with random gaps and random backpressure
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    tick($urandom_range(0, 2) == 0 ? 1 : 0);
                    send(DATA_W'($urandom), 1'($urandom), 4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        for (int w = 0; w < TIMEOUT && exp_q.size() != 0; w++) tick(1);
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // reset with two beats in flight
        out_ready = 1'b0;
        send(DATA_W'($urandom), 1'b0, 4'd1);
        send(DATA_W'($urandom), 1'b1, 4'd2);
        rst = 1'b1;
        exp_q.delete();
        out_cycs.delete();
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick(8);
        check("midrst_no_stale", 64'(out_cycs.size()), 64'd0);

        // pipe still works after a mid-flight reset
        send(32'h00000000, 1'b0, 4'd7);
        wait_outputs(1);
        check("post_midrst_beat", 64'(last_out_data), 64'h63636363);

        tick(4);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
